// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the MEM-stage data cache.
package dcache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned LINE_BITS  = 256;
    localparam int unsigned OFF_W      = 3;
    localparam int unsigned BYTE_W     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_e;

    // Index width for a given line count.
    function automatic int unsigned idx_w(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag width: whatever is left above index, word offset and byte offset.
    function automatic int unsigned tag_w(input int unsigned num_lines);
        return ADDR_W - idx_w(num_lines) - OFF_W - BYTE_W;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read, synchronous word or line write.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [idx_w(NUM_LINES)-1:0]       idx,
    output logic [tag_w(NUM_LINES)-1:0]       rd_tag,
    output logic                              rd_valid,
    output logic                              rd_dirty,
    output logic [LINE_BITS-1:0]              rd_line,
    input  logic                              word_we,
    input  logic [OFF_W-1:0]                  word_sel,
    input  logic [WORD_W-1:0]                 word_data,
    input  logic                              line_we,
    input  logic [tag_w(NUM_LINES)-1:0]       line_tag,
    input  logic [LINE_BITS-1:0]              line_data
);

    localparam int unsigned IDX_W = idx_w(NUM_LINES);
    localparam int unsigned TAG_W = tag_w(NUM_LINES);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    // Combinational read port.
    assign rd_tag   = tag_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_line  = data_q[idx];

    // Status bit updates: a fill validates and cleans, a store dirties.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (line_we) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end else if (word_we) begin
            dirty_d[idx] = 1'b1;
        end
    end

    // Status bits clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage are never cleared.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= line_tag;
            data_q[idx] <= line_data;
        end else if (word_we) begin
            data_q[idx][{word_sel, 5'b0} +: WORD_W] <= word_data;
        end
    end

    logic [IDX_W-1:0] unused_idx_c;
    assign unused_idx_c = idx;

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller for the MEM stage.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 32,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [WORD_W-1:0]     cpu_wdata,
    output logic [WORD_W-1:0]     cpu_rdata,
    output logic                  mem_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [LINE_BITS-1:0]  mem_wdata,
    input  logic [LINE_BITS-1:0]  mem_rdata,
    input  logic                  mem_ack
);

    localparam int unsigned IDX_W = idx_w(NUM_LINES);
    localparam int unsigned TAG_W = tag_w(NUM_LINES);

    state_e               state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]    miss_addr_q, miss_addr_d;
    logic [WORD_W-1:0]    rdata_q, rdata_d;

    logic [OFF_W-1:0]     req_off_c;
    logic [IDX_W-1:0]     req_idx_c, miss_idx_c, arr_idx_c;
    logic [TAG_W-1:0]     req_tag_c, miss_tag_c;
    logic [TAG_W-1:0]     rd_tag_c;
    logic                 rd_valid_c, rd_dirty_c;
    logic [LINE_BITS-1:0] rd_line_c;
    logic [WORD_W-1:0]    rd_word_c;
    logic                 hit_c, req_c;
    logic                 word_we_c, line_we_c;
    logic                 stall_c;
    logic [WORD_W-1:0]    rdata_c;

    // Address field split for the live request and the latched miss.
    assign req_off_c  = cpu_addr[BYTE_W +: OFF_W];
    assign req_idx_c  = cpu_addr[BYTE_W+OFF_W +: IDX_W];
    assign req_tag_c  = cpu_addr[ADDR_W-1 -: TAG_W];
    assign miss_idx_c = miss_addr_q[BYTE_W+OFF_W +: IDX_W];
    assign miss_tag_c = miss_addr_q[ADDR_W-1 -: TAG_W];
    assign arr_idx_c  = (state_q == IDLE) ? req_idx_c : miss_idx_c;

    dcache_array #(
        .NUM_LINES (NUM_LINES)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (arr_idx_c),
        .rd_tag    (rd_tag_c),
        .rd_valid  (rd_valid_c),
        .rd_dirty  (rd_dirty_c),
        .rd_line   (rd_line_c),
        .word_we   (word_we_c),
        .word_sel  (req_off_c),
        .word_data (cpu_wdata),
        .line_we   (line_we_c),
        .line_tag  (miss_tag_c),
        .line_data (mem_rdata)
    );

    // Hit detection against the indexed line.
    assign req_c     = cpu_read | cpu_write;
    assign hit_c     = rd_valid_c && (rd_tag_c == req_tag_c);
    assign rd_word_c = rd_line_c[{req_off_c, 5'b0} +: WORD_W];

    // Next-state, memory request and array-write decode.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        miss_addr_d = miss_addr_q;
        rdata_d     = rdata_q;
        rdata_c     = rdata_q;
        stall_c     = 1'b0;
        word_we_c   = 1'b0;
        line_we_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_c) begin
                    if (hit_c) begin
                        // Simultaneous read and write is treated as a write.
                        if (cpu_write) begin
                            word_we_c = 1'b1;
                        end else begin
                            rdata_c = rd_word_c;
                            rdata_d = rd_word_c;
                        end
                    end else begin
                        stall_c     = 1'b1;
                        mem_req_d   = 1'b1;
                        miss_addr_d = {req_tag_c, req_idx_c, 5'b0};
                        if (rd_valid_c && rd_dirty_c) begin
                            state_d     = WB;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {rd_tag_c, req_idx_c, 5'b0};
                            mem_wdata_d = rd_line_c;
                        end else begin
                            state_d    = FILL;
                            mem_we_d   = 1'b0;
                            mem_addr_d = {req_tag_c, req_idx_c, 5'b0};
                        end
                    end
                end
            end
            WB: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    state_d    = FILL;
                    mem_we_d   = 1'b0;
                    mem_addr_d = miss_addr_q;
                end
            end
            FILL: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    line_we_c = 1'b1;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and memory-interface registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            miss_addr_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miss_addr_q <= miss_addr_d;
            rdata_q     <= rdata_d;
        end
    end

    // Load data and stall are same-cycle; stall is forced low while in reset.
    assign cpu_rdata = rdata_c;
    assign mem_stall = stall_c & rst_n;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    logic [BYTE_W-1:0] unused_byte_c;
    assign unused_byte_c = cpu_addr[BYTE_W-1:0];

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed requests, a latency-3 memory model.
module tb_dcache_ctrl;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_read = 1'b0;
    logic         cpu_write = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         mem_stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;

    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } txn_t;

    txn_t        exp_tx[$];
    logic [31:0] exp_rd[$];
    int          errors = 0;
    int          checks = 0;
    bit          spur = 1'b0;
    int          stalls;

    dcache_ctrl #(.NUM_LINES(32), .LINE_WORDS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .mem_stall (mem_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    // Backing-memory contents: word i = {la[19:4], 12'h0, i}; word0 of line 0x40 is DEADBEEF.
    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {la[19:4], 12'h000, 4'(i)};
        if (la == 32'h0000_0040) l[31:0] = 32'hDEAD_BEEF;
        return l;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Memory responder: ack on the LAT-th cycle of each request.
    initial begin : responder
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end
            if (spur) begin
                spur      = 1'b0;
                mem_ack   = 1'b1;
                mem_rdata = '1;
            end else if (mem_req) begin
                cnt++;
                if (cnt == LAT) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_we ? '0 : mem_line(mem_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pop expected memory transactions and load results as the DUT presents them.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && mem_req && mem_ack) begin
                if (exp_tx.size() == 0) begin
                    chk("unexpected_mem_txn", {224'h0, mem_addr}, 256'h0);
                end else begin
                    txn_t t;
                    t = exp_tx.pop_front();
                    chk("mem_we", {255'h0, mem_we}, {255'h0, t.we});
                    chk("mem_addr", {224'h0, mem_addr}, {224'h0, t.addr});
                    if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
                end
            end
            if (rst_n && cpu_read && !cpu_write && !mem_stall) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_load", {224'h0, cpu_rdata}, 256'h0);
                end else begin
                    logic [31:0] e;
                    e = exp_rd.pop_front();
                    chk("cpu_rdata", {224'h0, cpu_rdata}, {224'h0, e});
                end
            end
        end
    end

    // Hold a request until stall is low, counting stalled cycles.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, output int n);
        bit done;
        @(posedge clk);
        #1;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = wd;
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            #2;
            if (mem_stall) n++;
            else done = 1'b1;
        end
        if (!done) chk("req_timeout", 256'h1, 256'h0);
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin : stim
        txn_t         t;
        logic [255:0] dl;
        bit           seen;

        // Reset state.
        #12;
        chk("rst_mem_req", {255'h0, mem_req}, 256'h0);
        chk("rst_mem_we", {255'h0, mem_we}, 256'h0);
        chk("rst_mem_addr", {224'h0, mem_addr}, 256'h0);
        chk("rst_mem_wdata", mem_wdata, 256'h0);
        chk("rst_cpu_rdata", {224'h0, cpu_rdata}, 256'h0);
        chk("rst_mem_stall", {255'h0, mem_stall}, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold read miss at 0x40.
        t = '{we: 1'b0, addr: 32'h40, wdata: '0};
        exp_tx.push_back(t);
        exp_rd.push_back(32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, stalls);
        chk("cold_miss_stalls", 256'(stalls), 256'd4);

        // Write hit then read hit on the resident line.
        do_req(1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, stalls);
        chk("write_hit_stalls", 256'(stalls), 256'd0);
        exp_rd.push_back(32'h1234_5678);
        do_req(1'b1, 1'b0, 32'h0000_0044, 32'h0, stalls);
        chk("read_hit_stalls", 256'(stalls), 256'd0);

        // Dirty eviction: write back 0x40 line with the stored word, then fill 0x440.
        dl = mem_line(32'h40);
        dl[63:32] = 32'h1234_5678;
        t = '{we: 1'b1, addr: 32'h40, wdata: dl};
        exp_tx.push_back(t);
        t = '{we: 1'b0, addr: 32'h440, wdata: '0};
        exp_tx.push_back(t);
        exp_rd.push_back(32'h0044_0001);
        do_req(1'b1, 1'b0, 32'h0000_0444, 32'h0, stalls);
        chk("dirty_miss_stalls", 256'(stalls), 256'd7);

        // Clean conflict miss: fill only.
        t = '{we: 1'b0, addr: 32'h40, wdata: '0};
        exp_tx.push_back(t);
        exp_rd.push_back(32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, stalls);
        chk("clean_miss_stalls", 256'(stalls), 256'd4);

        // Spurious ack in IDLE with no request.
        @(posedge clk);
        #1;
        spur = 1'b1;
        @(negedge clk);
        #2;
        chk("spur_ack_seen", {255'h0, mem_ack}, 256'h1);
        chk("spur_stall", {255'h0, mem_stall}, 256'h0);
        @(negedge clk);
        #2;
        chk("spur_mem_req", {255'h0, mem_req}, 256'h0);
        exp_rd.push_back(32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, stalls);
        chk("spur_after_read_stalls", 256'(stalls), 256'd0);

        // Reset in the middle of a fill of 0x840.
        @(posedge clk);
        #1;
        cpu_read = 1'b1;
        cpu_addr = 32'h0000_0840;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        chk("fill_req_seen", {255'h0, seen}, 256'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", {255'h0, mem_req}, 256'h0);
        chk("rst_mid_mem_stall", {255'h0, mem_stall}, 256'h0);
        cpu_read = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;

        // Previously resident line must miss again after reset.
        t = '{we: 1'b0, addr: 32'h40, wdata: '0};
        exp_tx.push_back(t);
        exp_rd.push_back(32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, stalls);
        chk("post_rst_miss_stalls", 256'(stalls), 256'd4);

        repeat (3) @(posedge clk);
        chk("tx_queue_drained", 256'(exp_tx.size()), 256'd0);
        chk("rd_queue_drained", 256'(exp_rd.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
